// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the IF / EX-MEM SRAM port arbiter.
// Tag encodings, the packed memory request layout and the response tag.
package sram_port_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    // {en, wen, addr, wdata}
    localparam int MEM_REQ_WD = 1 + 4 + 32 + 32;

    // CTRL's StallBus is one bit wider than before so it can OR in stallreq_for_mem.
    localparam int STALLREQ_MEM_WD = 1;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic valid;
        src_e src;
    } tag_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the instruction, data and shared-memory signals around the arbiter.
// The arbiter sits on the slave modport; the core and the SRAM sit on master.
interface sram_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stallreq_for_mem;

    modport slave (
        input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata, stallreq_for_mem
    );

    modport master (
        output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata, stallreq_for_mem
    );
endinterface

// File: rtl/sram_tag_pipe.sv
// DEPTH-stage shift register of {valid, src} tags that follows each access
// through the SRAM pipeline so its response can be routed back to its source.
module sram_tag_pipe
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [DEPTH-1:0] stage_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) stage_reg[gi] <= '0;
                    else     stage_reg[gi] <= tag_in;
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst) stage_reg[gi] <= '0;
                    else     stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one pipelined single-port SRAM between instruction fetch and data access:
// fixed data priority with an IF starvation guard, in-order response routing.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   bus
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic       grant_inst;
    logic       grant_data;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;
    mem_req_t   req;
    tag_t       tag_in;
    tag_t       tag_last;
    logic       resp_inst;
    logic       resp_data;

    // Nothing is granted while in reset, which also forces every request-side output low.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!rst) begin
            if (bus.data_req && bus.inst_req) begin
                if (wait_cnt_reg == MAX_WAIT_C) grant_inst = 1'b1;
                else                            grant_data = 1'b1;
            end else if (bus.data_req) begin
                grant_data = 1'b1;
            end else if (bus.inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    always_comb begin
        req = '0;
        if (grant_data) begin
            req.en    = 1'b1;
            req.wen   = bus.data_wen;
            req.addr  = bus.data_addr;
            req.wdata = bus.data_wdata;
        end else if (grant_inst) begin
            req.en    = 1'b1;
            req.addr  = bus.inst_addr;
        end
    end

    assign bus.mem_en    = req.en;
    assign bus.mem_wen   = req.wen;
    assign bus.mem_addr  = req.addr;
    assign bus.mem_wdata = req.wdata;

    assign bus.inst_addr_ok     = grant_inst;
    assign bus.data_addr_ok     = grant_data;
    assign bus.stallreq_for_mem = !rst && ((bus.inst_req && !grant_inst) ||
                                           (bus.data_req && !grant_data));

    // Counts consecutive cycles IF was refused; saturates at the starvation limit.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!bus.inst_req || grant_inst) wait_cnt_next = 4'd0;
        else if (wait_cnt_reg < MAX_WAIT_C) wait_cnt_next = wait_cnt_reg + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_reg <= 4'd0;
        else     wait_cnt_reg <= wait_cnt_next;
    end

    assign tag_in.valid = req.en;
    assign tag_in.src   = grant_data ? SRC_DATA : SRC_INST;

    sram_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_last)
    );

    assign resp_inst = !rst && tag_last.valid && (tag_last.src == SRC_INST);
    assign resp_data = !rst && tag_last.valid && (tag_last.src == SRC_DATA);

    assign bus.inst_data_ok = resp_inst;
    assign bus.data_data_ok = resp_data;
    assign bus.inst_rdata   = resp_inst ? bus.mem_rdata : 32'd0;
    assign bus.data_rdata   = resp_data ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: a driver predicts each cycle's grant and
// each response from a word-level memory model; a negedge monitor checks them.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int LAT  = 3;
    localparam int MAXW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_port_arbiter_if bus();

    sram_port_arbiter #(
        .MEM_LAT  (LAT),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- SRAM behavioural model (environment) ----------------
    logic [31:0] mem     [64] = '{default: 32'd0};
    logic [31:0] rd_pipe [LAT] = '{default: 32'hDEADBEEF};

    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        if (bus.mem_en) begin
            if (bus.mem_wen != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wen[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                rd_pipe[0] <= 32'd0;
            end else begin
                rd_pipe[0] <= mem[bus.mem_addr[7:2]];
            end
        end else begin
            rd_pipe[0] <= 32'hDEADBEEF;
        end
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int          cyc;
        bit          iok;
        bit          dok;
        bit          en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          stall;
    } cyc_exp_t;

    typedef struct {
        int          due;
        bit          src;
        logic [31:0] data;
    } resp_exp_t;

    cyc_exp_t  cyc_q  [$];
    resp_exp_t resp_q [$];
    logic [31:0] ref_mem [64] = '{default: 32'd0};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Pending requests: each is held on the bus until the model says it was taken.
    bit          ip = 1'b0;
    logic [31:0] ia = 32'd0;
    bit          dp = 1'b0;
    logic [3:0]  dw = 4'd0;
    logic [31:0] da = 32'd0;
    logic [31:0] dd = 32'd0;
    int          waited = 0;

    initial begin
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'd0;
        bus.data_req   = 1'b0;
        bus.data_wen   = 4'd0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r);
        cyc_exp_t  e;
        resp_exp_t x;
        bit        gi;
        bit        gd;
        @(posedge clk);
        #1;
        rst            = r;
        bus.inst_req   = ip;
        bus.inst_addr  = ia;
        bus.data_req   = dp;
        bus.data_wen   = dw;
        bus.data_addr  = da;
        bus.data_wdata = dd;
        e = '{cyc: cyc, iok: 0, dok: 0, en: 0, wen: 4'd0, addr: 32'd0, wdata: 32'd0, stall: 0};
        if (r) begin
            waited = 0;
            while (resp_q.size() > 0 && resp_q[$].due >= cyc) void'(resp_q.pop_back());
        end else begin
            gi = ip && (!dp || waited >= MAXW);
            gd = dp && !gi;
            waited  = (ip && !gi) ? ((waited < MAXW) ? waited + 1 : MAXW) : 0;
            e.iok   = gi;
            e.dok   = gd;
            e.stall = (ip && !gi) || (dp && !gd);
            if (gd) begin
                e.en = 1; e.wen = dw; e.addr = da; e.wdata = dd;
                x.due = cyc + LAT; x.src = 1'b1;
                if (dw == 4'd0) begin
                    x.data = ref_mem[da[7:2]];
                end else begin
                    x.data = 32'd0;
                    for (int b = 0; b < 4; b++)
                        if (dw[b]) ref_mem[da[7:2]][8*b +: 8] = dd[8*b +: 8];
                end
                resp_q.push_back(x);
                dp = 1'b0;
            end else if (gi) begin
                e.en = 1; e.addr = ia;
                x.due = cyc + LAT; x.src = 1'b0; x.data = ref_mem[ia[7:2]];
                resp_q.push_back(x);
                ip = 1'b0;
            end
        end
        cyc_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        cyc_exp_t  e;
        resp_exp_t x;
        if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
            e = cyc_q.pop_front();
            chk("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(e.iok));
            chk("data_addr_ok", 32'(bus.data_addr_ok), 32'(e.dok));
            chk("mem_en", 32'(bus.mem_en), 32'(e.en));
            chk("mem_wen", 32'(bus.mem_wen), 32'(e.wen));
            chk("mem_addr", bus.mem_addr, e.addr);
            chk("mem_wdata", bus.mem_wdata, e.wdata);
            chk("stallreq", 32'(bus.stallreq_for_mem), 32'(e.stall));
            if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
                x = resp_q.pop_front();
                $display("[TB] cyc=%0d resp src=%0d data=%h", cyc, x.src, x.data);
                chk("inst_data_ok", 32'(bus.inst_data_ok), 32'(!x.src));
                chk("data_data_ok", 32'(bus.data_data_ok), 32'(x.src));
                chk("inst_rdata", bus.inst_rdata, x.src ? 32'd0 : x.data);
                chk("data_rdata", bus.data_rdata, x.src ? x.data : 32'd0);
            end else begin
                chk("inst_data_ok_idle", 32'(bus.inst_data_ok), 32'd0);
                chk("data_data_ok_idle", 32'(bus.data_data_ok), 32'd0);
                chk("inst_rdata_idle", bus.inst_rdata, 32'd0);
                chk("data_rdata_idle", bus.data_rdata, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        step(1'b1); step(1'b1); step(1'b1);

        // Fetch-only stream on consecutive cycles.
        ip = 1; ia = 32'hBFC00000; step(1'b0);
        ip = 1; ia = 32'hBFC00004; step(1'b0);
        idle(LAT + 1);

        // Both requesters busy: data wins MAXW times, then fetch gets through.
        ip = 1; ia = 32'hBFC00008;
        for (int i = 0; i < 6; i++) begin
            if (!dp) begin dp = 1; dw = 4'd0; da = 32'h40 + 32'(4 * i); dd = 32'd0; end
            step(1'b0);
        end
        for (int i = 0; i < 10 && (ip || dp); i++) step(1'b0);
        idle(LAT + 1);

        // Fetch, full-word write, read-back of the same word.
        ip = 1; ia = 32'h00000080; step(1'b0);
        dp = 1; dw = 4'hF; da = 32'h80; dd = 32'h12345678; step(1'b0);
        dp = 1; dw = 4'h0; da = 32'h80; dd = 32'd0; step(1'b0);
        idle(LAT + 1);

        // Single byte-lane write into a zero word.
        dp = 1; dw = 4'b0010; da = 32'hFC; dd = 32'hAABBCCDD; step(1'b0);
        dp = 1; dw = 4'b0000; da = 32'hFC; dd = 32'd0; step(1'b0);
        idle(LAT + 1);

        // Reads in flight when reset hits are dropped.
        dp = 1; dw = 4'd0; da = 32'h80; step(1'b0);
        dp = 1; dw = 4'd0; da = 32'hFC; step(1'b0);
        step(1'b1);
        idle(LAT + 2);

        // Quiet bus.
        idle(4);

        for (int n = 0; n < 3000; n++) begin
            if (!ip && ($urandom % 3 == 0)) begin
                ip = 1; ia = 32'hBFC00000 | (32'($urandom_range(0, 63)) << 2);
            end
            if (!dp && ($urandom % 2 == 0)) begin
                dp = 1;
                dw = ($urandom % 3 == 0) ? 4'($urandom) : 4'd0;
                da = 32'($urandom_range(0, 63)) << 2;
                dd = $urandom;
            end
            step($urandom % 100 == 0);
        end
        for (int i = 0; i < 20 && (ip || dp); i++) step(1'b0);
        idle(LAT + 2);
        @(negedge clk);
        #1;
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
